// File: rtl/float_add_seq.sv
// ============================================================================
//  Module      : float_add_seq
//  Description : Operand sequencer placed in front of a float_add unit.
//                Operand/op triples arrive over a valid/ready stream and are
//                buffered in a DEPTH-entry FIFO. A three-state controller
//                (IDLE/ISSUE/DRAIN) drives the unit's en/fin protocol one
//                operation at a time. Each result is held in an output
//                register with its own valid/ready handshake. A per-operation
//                timeout replaces a missing fin with a quiet NaN and an error
//                flag, so one hung operation cannot stall the stream.
//
//  Ports       : clk, rst (async, active-low)
//                in_valid/in_ready/in_a/in_b/in_op   operand stream
//                out_valid/out_ready/out_result/out_err  result stream
//                fu_A/fu_B/fu_c/fu_en/fu_result/fu_fin   float_add link
//                busy, count                          status
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module float_add_seq #(
    parameter int DEPTH   = 4,   // FIFO entries, power of 2, >= 2
    parameter int TIMEOUT = 16,  // max cycles fu_en waits for fu_fin, >= 2
    parameter int GAP     = 1    // min cycles fu_en low between operations, >= 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_a,
    input  logic [31:0]                  in_b,
    input  logic [1:0]                   in_op,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_result,
    output logic                         out_err,
    output logic [31:0]                  fu_A,
    output logic [31:0]                  fu_B,
    output logic [1:0]                   fu_c,
    output logic                         fu_en,
    input  logic [31:0]                  fu_result,
    input  logic                         fu_fin,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH + 1);
    localparam int c_TW = $clog2(TIMEOUT);
    localparam int c_GW = $clog2(GAP + 1);

    localparam logic [31:0] c_QNAN = 32'h7fc0_0000;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    // ------------------------------------------------------------------
    // Operand FIFO: each entry is {op, a, b}
    // ------------------------------------------------------------------
    logic [65:0]        r_mem [DEPTH];
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_CW-1:0]    r_count;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [65:0]        w_head;

    // ------------------------------------------------------------------
    // Controller and output registers
    // ------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [c_TW-1:0]    r_timer;
    logic [c_GW-1:0]    r_gap;
    logic [31:0]        r_fu_a;
    logic [31:0]        r_fu_b;
    logic [1:0]         r_fu_c;
    logic               r_fu_en;
    logic               r_out_valid;
    logic [31:0]        r_out_result;
    logic               r_out_err;

    logic               w_timeout;
    logic               w_gap_done;
    logic               w_drain_done;

    assign w_full   = (r_count == c_CW'(DEPTH));
    assign w_empty  = (r_count == '0);

    // in_ready is forced low during reset and depends only on fullness, so a
    // pop in the same cycle never opens a slot early (no pass-through).
    assign in_ready = rst & ~w_full;
    assign w_push   = in_valid & in_ready;
    assign w_pop    = (r_state == c_ST_IDLE) & ~w_empty;
    assign w_head   = r_mem[r_rd_ptr];

    assign w_timeout    = (r_timer == c_TW'(TIMEOUT - 1));
    assign w_gap_done   = (int'(r_gap) >= (GAP - 1));
    // Leave DRAIN only once the result slot is (being) freed, the unit has
    // dropped fin, and the minimum en-low gap has elapsed.
    assign w_drain_done = (~r_out_valid | out_ready) & ~fu_fin & w_gap_done;

    // Storage array needs no reset; occupancy is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_op, in_a, in_b};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= c_ST_IDLE;
            r_timer      <= '0;
            r_gap        <= '0;
            r_fu_a       <= '0;
            r_fu_b       <= '0;
            r_fu_c       <= '0;
            r_fu_en      <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_err    <= 1'b0;
        end else begin
            // Consumer handshake; a capture below can only happen in ISSUE,
            // which is never entered while out_valid is set.
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (w_pop) begin
                        r_fu_b  <= w_head[31:0];
                        r_fu_a  <= w_head[63:32];
                        r_fu_c  <= w_head[65:64];
                        r_fu_en <= 1'b1;
                        r_timer <= '0;
                        r_state <= c_ST_ISSUE;
                    end
                end

                c_ST_ISSUE: begin
                    // fin wins over a timeout landing in the same cycle.
                    if (fu_fin) begin
                        r_out_result <= fu_result;
                        r_out_err    <= 1'b0;
                        r_out_valid  <= 1'b1;
                        r_fu_en      <= 1'b0;
                        r_gap        <= '0;
                        r_state      <= c_ST_DRAIN;
                    end else if (w_timeout) begin
                        r_out_result <= c_QNAN;
                        r_out_err    <= 1'b1;
                        r_out_valid  <= 1'b1;
                        r_fu_en      <= 1'b0;
                        r_gap        <= '0;
                        r_state      <= c_ST_DRAIN;
                    end else begin
                        r_timer <= r_timer + c_TW'(1);
                    end
                end

                c_ST_DRAIN: begin
                    if (w_drain_done) begin
                        r_state <= c_ST_IDLE;
                    end else if (!(&r_gap)) begin
                        r_gap <= r_gap + c_GW'(1);
                    end
                end

                default: begin
                    r_fu_en <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign fu_A       = r_fu_a;
    assign fu_B       = r_fu_b;
    assign fu_c       = r_fu_c;
    assign fu_en      = r_fu_en;
    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_err    = r_out_err;
    assign busy       = (r_state != c_ST_IDLE) | ~w_empty;
    assign count      = r_count;

endmodule

`default_nettype wire

// File: tb/tb_float_add_seq.sv
// ============================================================================
//  Module      : tb_float_add_seq
//  Description : Self-checking bench for float_add_seq. A behavioural
//                float_add stand-in (adder with programmable latency and a
//                hang switch) sits on the fu_* link. Expected results are
//                computed from operand values with plain integer arithmetic
//                on half-unit values.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_float_add_seq;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;
    localparam int GAP     = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [1:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_err;
    logic [31:0] fu_A;
    logic [31:0] fu_B;
    logic [1:0]  fu_c;
    logic        fu_en;
    logic [31:0] fu_result;
    logic        fu_fin;
    logic        busy;
    logic [2:0]  count;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    float_add_seq #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_err(out_err),
        .fu_A(fu_A), .fu_B(fu_B), .fu_c(fu_c), .fu_en(fu_en),
        .fu_result(fu_result), .fu_fin(fu_fin),
        .busy(busy), .count(count)
    );

    // ---------------- value helpers (operands are multiples of 0.5) -------
    function automatic int f2h(input logic [31:0] f);
        int e;
        int m;
        int sh;
        int v;
        e = int'(f[30:23]);
        if (e == 0) return 0;
        m  = int'({1'b1, f[22:0]});
        sh = e - 149;
        v  = (sh >= 0) ? (m << sh) : (m >> (-sh));
        return f[31] ? -v : v;
    endfunction

    function automatic logic [31:0] h2f(input int h);
        int          a;
        int          p;
        logic [31:0] tmp;
        logic [7:0]  e;
        if (h == 0) return 32'h0;
        a = (h < 0) ? -h : h;
        p = 0;
        for (int i = 0; i < 24; i++) if (a >= (1 << i)) p = i;
        tmp = 32'(a) << (23 - p);
        e   = 8'(p - 1 + 127);
        return {(h < 0), e, tmp[22:0]};
    endfunction

    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        return h2f(f2h(a) + f2h(b));
    endfunction

    function automatic logic [31:0] rand_f();
        return h2f(int'($urandom_range(0, 4000)) - 2000);
    endfunction

    // ---------------- float_add stand-in ----------------------------------
    logic fu_hang;
    int   fu_lat;
    int   fu_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fu_fin    <= 1'b0;
            fu_cnt    <= 0;
            fu_result <= 32'h0;
        end else if (!fu_en) begin
            fu_fin <= 1'b0;
            fu_cnt <= 0;
        end else if (!fu_hang && !fu_fin) begin
            if (fu_cnt >= fu_lat) begin
                fu_fin    <= 1'b1;
                fu_result <= ref_add(fu_A, fu_B);
            end else begin
                fu_cnt <= fu_cnt + 1;
            end
        end
    end

    // ---------------- output / en-activity monitor ------------------------
    logic [32:0] got_q[$];
    int en_run, low_run, last_en_run, min_gap;
    bit seen_hi;

    always @(negedge clk) begin
        if (!rst) begin
            en_run = 0; low_run = 0; seen_hi = 0;
        end else begin
            if (out_valid && out_ready) got_q.push_back({out_err, out_result});
            if (fu_en) begin
                if (en_run == 0 && seen_hi && low_run < min_gap) min_gap = low_run;
                en_run++;
                low_run = 0;
            end else begin
                if (en_run > 0) begin
                    last_en_run = en_run;
                    seen_hi     = 1;
                end
                en_run = 0;
                low_run++;
            end
        end
    end

    // ---------------- drive helpers ---------------------------------------
    task automatic push_one(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        bit ok;
        ok = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = a; in_b = b; in_op = op;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            else begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            $display("FAIL push_timeout: in_ready stayed 0 for %h+%h", a, b);
        end
    endtask

    task automatic wait_got(input int n);
        for (int i = 0; i < 3000 && got_q.size() < n; i++) begin
            @(negedge clk); #1;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 500 && (busy || out_valid); i++) begin
            @(negedge clk); #1;
        end
    endtask

    // ---------------- tests -----------------------------------------------
    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
        out_ready = 1'b1; fu_hang = 1'b0; fu_lat = 2; min_gap = 1000;
        repeat (3) @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready); else n_pass++;
        n_checks++;
        if ({fu_en, out_valid, out_err, busy} !== 4'b0)
            $display("FAIL reset_flags: en/ov/err/busy got %b want 0000", {fu_en, out_valid, out_err, busy});
        else n_pass++;
        n_checks++;
        if ({count, out_result, fu_A, fu_B, fu_c} !== '0)
            $display("FAIL reset_regs: count %0d res %h A %h B %h c %b want all 0", count, out_result, fu_A, fu_B, fu_c);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_single();
        got_q.delete();
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = 32'hc0a00000; in_b = 32'hc0900000; in_op = 2'b00;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL single_ready: got %b want 1", in_ready); else n_pass++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++;
        if ({fu_en, count} !== {1'b0, 3'd1}) $display("FAIL single_after_push: en %b count %0d want 0 1", fu_en, count); else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if ({fu_en, fu_A, fu_B, fu_c} !== {1'b1, 32'hc0a00000, 32'hc0900000, 2'b00})
            $display("FAIL single_issue: en %b A %h B %h c %b want 1 c0a00000 c0900000 00", fu_en, fu_A, fu_B, fu_c);
        else n_pass++;
        wait_got(1);
        n_checks++;
        if (got_q.size() < 1) $display("FAIL single_result: got none want c1180000");
        else if (got_q[0] !== {1'b0, 32'hc1180000}) $display("FAIL single_result: got %h want 0c1180000", got_q[0]);
        else n_pass++;
        repeat (4) @(negedge clk);
        n_checks++;
        if ({out_valid, fu_en, out_result} !== {2'b00, 32'hc1180000})
            $display("FAIL single_hold: ov %b en %b res %h want 0 0 c1180000", out_valid, fu_en, out_result);
        else n_pass++;
    endtask

    task automatic test_burst();
        logic [31:0] ba[4];
        logic [31:0] bb[4];
        logic [31:0] be[4];
        int bad_ready, max_cnt;
        ba = '{32'h40a00000, 32'hc0400000, 32'hc0400000, 32'hc0a00000};
        bb = '{32'h40900000, 32'hc0000000, 32'h40000000, 32'hc0900000};
        be = '{32'h41180000, 32'hc0a00000, 32'hbf800000, 32'hc1180000};
        got_q.delete();
        bad_ready = 0; max_cnt = 0; min_gap = 1000; fu_lat = 2;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_a = ba[i]; in_b = bb[i]; in_op = 2'b00;
            @(negedge clk);
            if (in_ready !== 1'b1) bad_ready++;
            if (int'(count) > max_cnt) max_cnt = int'(count);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 3000 && got_q.size() < 4; i++) begin
            @(negedge clk); #1;
            if (int'(count) > max_cnt) max_cnt = int'(count);
        end
        n_checks++;
        if (bad_ready != 0 || max_cnt > 4) $display("FAIL burst_ready: stalls %0d peak %0d want 0 <=4", bad_ready, max_cnt); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (got_q.size() <= i) $display("FAIL burst_result%0d: got none want %h", i, be[i]);
            else if (got_q[i] !== {1'b0, be[i]}) $display("FAIL burst_result%0d: got %h want 0%h", i, got_q[i], be[i]);
            else n_pass++;
        end
        n_checks++;
        if (min_gap < GAP || min_gap == 1000) $display("FAIL burst_gap: min en-low run %0d want >=%0d", min_gap, GAP); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [31:0] xa[6];
        logic [31:0] xb[6];
        int idx, bad;
        for (int i = 0; i < 6; i++) begin xa[i] = rand_f(); xb[i] = rand_f(); end
        wait_idle();
        got_q.delete();
        idx = 0; bad = 0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int c = 0; c < 50; c++) begin
            in_valid = (idx < 6);
            if (idx < 6) begin in_a = xa[idx]; in_b = xb[idx]; in_op = 2'b00; end
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            if (count == 3'd4 && in_ready !== 1'b0) bad++;
            if (out_valid && fu_en) bad++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (idx != 5 || bad != 0) $display("FAIL bp_accept: accepted %0d violations %0d want 5 0", idx, bad); else n_pass++;
        n_checks++;
        if ({count, in_ready, out_valid, fu_en} !== {3'd4, 1'b0, 1'b1, 1'b0})
            $display("FAIL bp_stall: count %0d rdy %b ov %b en %b want 4 0 1 0", count, in_ready, out_valid, fu_en);
        else n_pass++;
        n_checks++;
        if (got_q.size() != 0 || out_result !== ref_add(xa[0], xb[0]))
            $display("FAIL bp_held: consumed %0d res %h want 0 %h", got_q.size(), out_result, ref_add(xa[0], xb[0]));
        else n_pass++;
        out_ready = 1'b1;
        for (int c = 0; c < 300 && idx < 6; c++) begin
            in_valid = 1'b1; in_a = xa[idx]; in_b = xb[idx];
            @(negedge clk);
            if (in_ready) idx++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_got(6);
        repeat (20) @(negedge clk);
        n_checks++;
        if (got_q.size() != 6) $display("FAIL bp_count: got %0d results want 6", got_q.size()); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (got_q.size() <= i) $display("FAIL bp_result%0d: got none want %h", i, ref_add(xa[i], xb[i]));
            else if (got_q[i] !== {1'b0, ref_add(xa[i], xb[i])})
                $display("FAIL bp_result%0d: got %h want 0%h", i, got_q[i], ref_add(xa[i], xb[i]));
            else n_pass++;
        end
    endtask

    task automatic test_timeout();
        logic [31:0] a2, b2;
        int run1;
        a2 = rand_f(); b2 = rand_f();
        wait_idle();
        got_q.delete();
        out_ready = 1'b1; fu_hang = 1'b1;
        push_one(32'h40a00000, 32'h40900000, 2'b00);
        push_one(a2, b2, 2'b00);
        wait_got(1);
        run1 = last_en_run;
        fu_hang = 1'b0;
        n_checks++;
        if (run1 != TIMEOUT) $display("FAIL timeout_len: fu_en high %0d cycles want %0d", run1, TIMEOUT); else n_pass++;
        n_checks++;
        if (got_q.size() < 1) $display("FAIL timeout_result: got none want 17fc00000");
        else if (got_q[0] !== {1'b1, 32'h7fc00000}) $display("FAIL timeout_result: got %h want 17fc00000", got_q[0]);
        else n_pass++;
        wait_got(2);
        n_checks++;
        if (got_q.size() < 2) $display("FAIL timeout_next: got none want %h", ref_add(a2, b2));
        else if (got_q[1] !== {1'b0, ref_add(a2, b2)}) $display("FAIL timeout_next: got %h want 0%h", got_q[1], ref_add(a2, b2));
        else n_pass++;
    endtask

    task automatic test_full_pop();
        logic [31:0] xa[6];
        logic [31:0] xb[6];
        int bad;
        bit seen;
        for (int i = 0; i < 6; i++) begin xa[i] = rand_f(); xb[i] = rand_f(); end
        wait_idle();
        got_q.delete();
        out_ready = 1'b0; fu_lat = 2; bad = 0; seen = 0;
        for (int i = 0; i < 5; i++) push_one(xa[i], xb[i], 2'b00);
        for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
        n_checks++;
        if ({count, out_valid} !== {3'd4, 1'b1}) $display("FAIL fullpop_setup: count %0d ov %b want 4 1", count, out_valid); else n_pass++;
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = xa[5]; in_b = xb[5]; in_op = 2'b00;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (fu_en) seen = 1;
            else if (in_ready !== 1'b0) bad++;
        end
        n_checks++;
        if (!seen || bad != 0 || count !== 3'd3 || in_ready !== 1'b1)
            $display("FAIL fullpop_pop: seen %b early-ready %0d count %0d rdy %b want 1 0 3 1", seen, bad, count, in_ready);
        else n_pass++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (count !== 3'd4) $display("FAIL fullpop_refill: count %0d want 4", count); else n_pass++;
        wait_got(6);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (got_q.size() <= i) $display("FAIL fullpop_result%0d: got none want %h", i, ref_add(xa[i], xb[i]));
            else if (got_q[i] !== {1'b0, ref_add(xa[i], xb[i])})
                $display("FAIL fullpop_result%0d: got %h want 0%h", i, got_q[i], ref_add(xa[i], xb[i]));
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [31:0] xa[20];
        logic [31:0] xb[20];
        logic [1:0]  xo[20];
        int idx, iss, bad_issue;
        bit prev_en;
        for (int i = 0; i < 20; i++) begin
            xa[i] = rand_f(); xb[i] = rand_f(); xo[i] = 2'($urandom_range(0, 3));
        end
        wait_idle();
        got_q.delete();
        idx = 0; iss = 0; bad_issue = 0; prev_en = 0;
        for (int c = 0; c < 4000 && got_q.size() < 20; c++) begin
            @(posedge clk); #1;
            out_ready = 1'($urandom_range(0, 1));
            fu_lat    = int'($urandom_range(0, 4));
            in_valid  = (idx < 20) && ($urandom_range(0, 3) != 0);
            if (idx < 20) begin in_a = xa[idx]; in_b = xb[idx]; in_op = xo[idx]; end
            @(negedge clk); #1;
            if (in_valid && in_ready) idx++;
            if (fu_en && !prev_en) begin
                if (iss >= 20 || {fu_A, fu_B, fu_c} !== {xa[iss], xb[iss], xo[iss]}) bad_issue++;
                iss++;
            end
            prev_en = fu_en;
        end
        in_valid = 1'b0; out_ready = 1'b1; fu_lat = 2;
        n_checks++;
        if (iss != 20 || bad_issue != 0) $display("FAIL rand_issue: issued %0d bad %0d want 20 0", iss, bad_issue); else n_pass++;
        n_checks++;
        if (got_q.size() != 20) $display("FAIL rand_count: got %0d want 20", got_q.size()); else n_pass++;
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if (got_q.size() <= i) $display("FAIL rand_result%0d: got none want %h", i, ref_add(xa[i], xb[i]));
            else if (got_q[i] !== {1'b0, ref_add(xa[i], xb[i])})
                $display("FAIL rand_result%0d: got %h want 0%h", i, got_q[i], ref_add(xa[i], xb[i]));
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] a4, b4;
        a4 = rand_f(); b4 = rand_f();
        wait_idle();
        out_ready = 1'b1; fu_lat = 8;
        push_one(32'h40a00000, 32'h40900000, 2'b00);
        push_one(32'hc0400000, 32'hc0000000, 2'b00);
        push_one(32'hc0400000, 32'h40000000, 2'b00);
        n_checks++;
        if ({fu_en, count} !== {1'b1, 3'd2}) $display("FAIL rstmid_pre: en %b count %0d want 1 2", fu_en, count); else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({fu_en, out_valid, count, in_ready} !== {2'b00, 3'd0, 1'b0})
            $display("FAIL rstmid_async: en %b ov %b count %0d rdy %b want 0 0 0 0", fu_en, out_valid, count, in_ready);
        else n_pass++;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        got_q.delete();
        fu_lat = 2;
        push_one(a4, b4, 2'b00);
        wait_got(1);
        repeat (30) @(negedge clk);
        n_checks++;
        if (got_q.size() != 1) $display("FAIL rstmid_count: got %0d results want 1", got_q.size());
        else if (got_q[0] !== {1'b0, ref_add(a4, b4)}) $display("FAIL rstmid_result: got %h want 0%h", got_q[0], ref_add(a4, b4));
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_timeout();
        test_full_pop();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
